spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_arb_timer.sv | 28 ++
 rtl/spi_arbiter.sv | 133 +++++++++++++
 tb/tb_spi_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the two-requester SPI arbiter.
package spi_pkg;

  localparam int LEN_W_DEF         = 16;
  localparam int START_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_RUN,
    ST_DONE
  } arb_state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/spi_arb_timer.sv
// Clearable saturating cycle counter; expire flags the final counted cycle.
module spi_arb_timer #(
  parameter int MAX = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] count;

  // Holds at MAX so a long stall can never wrap back into range.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != CW'(MAX)))
      count <= count + 1'b1;
  end

  assign expire = (count == CW'(MAX - 1));

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter handing one SPI engine to two requesters; all outputs registered.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int LEN_W         = LEN_W_DEF,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             op0,
  input  logic [LEN_W-1:0] len0,
  output logic             gnt0,
  output logic             done0,
  input  logic             req1,
  input  logic             op1,
  input  logic [LEN_W-1:0] len1,
  output logic             gnt1,
  output logic             done1,
  output logic             work,
  output logic             op,
  output logic [LEN_W-1:0] len,
  input  logic             busy,
  output logic             sel,
  output logic             err
);

  arb_state_t       state, state_nxt;
  logic             last_ptr, last_d;
  logic [1:0]       gnt_q, gnt_d, done_q, done_d;
  logic             work_d, err_d, op_d, sel_d;
  logic [LEN_W-1:0] len_d;
  logic             winner;
  logic [LEN_W-1:0] win_len;
  logic             tmr_expire;

  spi_arb_timer #(.MAX(START_TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == ST_START),
    .inc    (state == ST_WAIT),
    .expire (tmr_expire)
  );

  // On a tie the requester that did not own the previous transfer wins.
  assign winner  = (req0 && req1) ? ~last_ptr : req1;
  assign win_len = winner ? len1 : len0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      last_ptr <= 1'b1;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      work     <= 1'b0;
      err      <= 1'b0;
      op       <= 1'b0;
      len      <= '0;
      sel      <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_ptr <= last_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      work     <= work_d;
      err      <= err_d;
      op       <= op_d;
      len      <= len_d;
      sel      <= sel_d;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (req0 || req1) state_nxt = (win_len == '0) ? ST_DONE : ST_START;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (busy)            state_nxt = ST_RUN;
        else if (tmr_expire) state_nxt = ST_DONE;
      end
      ST_RUN:   if (!busy) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Computes the values the output registers take on the coming edge.
  always_comb begin
    gnt_d  = gnt_q;
    done_d = 2'b00;
    work_d = 1'b0;
    err_d  = 1'b0;
    op_d   = op;
    len_d  = len;
    sel_d  = sel;
    last_d = last_ptr;
    unique case (state)
      ST_IDLE: begin
        if (req0 || req1) begin
          sel_d = winner;
          op_d  = winner ? op1 : op0;
          len_d = win_len;
          gnt_d = onehot2(winner);
          if (win_len == '0) begin
            done_d = onehot2(winner);
            err_d  = 1'b1;
          end else begin
            work_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!busy && tmr_expire) begin
          done_d = gnt_q;
          err_d  = 1'b1;
        end
      end
      ST_RUN:   if (!busy) done_d = gnt_q;
      ST_DONE: begin
        gnt_d  = 2'b00;
        last_d = sel;
      end
      default: ;
    endcase
  end

  assign gnt0  = gnt_q[0];
  assign gnt1  = gnt_q[1];
  assign done0 = done_q[0];
  assign done1 = done_q[1];

endmodule

// File: tb/tb_spi_arbiter.sv
// Randomized bench for spi_arbiter against a transaction-level round-robin/latency model.
module tb_spi_arbiter;

  localparam int LW = 16;
  localparam int TO = 64;

  logic          clk = 1'b0, rst = 1'b1;
  logic          req0 = 1'b0, op0 = 1'b0, req1 = 1'b0, op1 = 1'b0, busy = 1'b0;
  logic [LW-1:0] len0 = '0, len1 = '0;
  logic          gnt0, gnt1, done0, done1, work, op, sel, err;
  logic [LW-1:0] len;

  int total = 0;
  int bad   = 0;
  bit last_m = 1'b1;
  logic obs;

  spi_arbiter #(.LEN_W(LW), .START_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .len0(len0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .op1(op1), .len1(len1), .gnt1(gnt1), .done1(done1),
    .work(work), .op(op), .len(len), .busy(busy), .sel(sel), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One whole transfer from an IDLE cycle; busy rises d cycles after work and stays h cycles.
  task automatic apply_stimulus(input bit r0, input bit r1, input bit o0, input bit o1,
                                input logic [LW-1:0] l0, input logic [LW-1:0] l1,
                                input int d, input int h, input bit tmo, output logic obs_sel);
    bit            win, exp_op;
    logic [LW-1:0] exp_len;
    logic [1:0]    oh;
    int            exp_n, n;
    @(negedge clk);
    req0 = r0; req1 = r1; op0 = o0; op1 = o1; len0 = l0; len1 = l1; busy = 1'b0;
    win     = (r0 && r1) ? ~last_m : r1;
    exp_op  = win ? o1 : o0;
    exp_len = win ? l1 : l0;
    oh      = win ? 2'b10 : 2'b01;
    @(posedge clk); #1;
    obs_sel = sel;
    check_output("grant", 32'({gnt1, gnt0}), 32'(oh));
    check_output("sel", 32'(sel), 32'(win));
    check_output("op", 32'(op), 32'(exp_op));
    check_output("len", 32'(len), 32'(exp_len));
    if (exp_len == '0) begin
      check_output("zl_work", 32'(work), 32'd0);
      check_output("zl_done", 32'({done1, done0}), 32'(oh));
      check_output("zl_err", 32'(err), 32'd1);
    end else begin
      check_output("work", 32'(work), 32'd1);
      check_output("early_done", 32'({done1, done0}), 32'd0);
      exp_n = tmo ? TO + 1 : d + h + 1;
      n = 0;
      for (int i = 1; i <= exp_n + 4; i++) begin
        @(negedge clk);
        busy = !tmo && (i - 1 >= d) && (i - 1 < d + h);
        if ($urandom_range(0, 3) == 0) begin
          req0 = 1'($urandom_range(0, 1));
          req1 = 1'($urandom_range(0, 1));
          op0  = 1'($urandom_range(0, 1));
          op1  = 1'($urandom_range(0, 1));
          len0 = LW'($urandom);
          len1 = LW'($urandom);
        end
        @(posedge clk); #1;
        if (done0 || done1) begin
          n = i;
          break;
        end
        check_output("work_once", 32'(work), 32'd0);
        check_output("hold_gnt", 32'({gnt1, gnt0}), 32'(oh));
        check_output("hold_oplen", 32'({sel, op, len}), 32'({win, exp_op, exp_len}));
        check_output("no_err", 32'(err), 32'd0);
      end
      check_output("done_lat", 32'(n), 32'(exp_n));
      check_output("done", 32'({done1, done0}), 32'(oh));
      check_output("err", 32'(err), 32'(tmo));
      check_output("done_oplen", 32'({sel, op, len}), 32'({win, exp_op, exp_len}));
    end
    last_m = win;
    busy = 1'b0;
    @(posedge clk); #1;
    check_output("idle_gnt", 32'({gnt1, gnt0}), 32'd0);
    check_output("idle_done", 32'({done1, done0, err, work}), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit r0, r1;
    logic [LW-1:0] l0, l1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check_output("rst_outs", 32'({gnt1, gnt0, done1, done0, work, err, op, sel}), 32'd0);
    check_output("rst_len", 32'(len), 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_output("noreq_idle", 32'({gnt1, gnt0, work, done1, done0}), 32'd0);
    end

    // Both requesters held from reset: ownership must alternate starting with 0.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'd7, 16'd9, 2, 2, 1'b0, obs);
      check_output("rr_order", 32'(obs), 32'(i % 2));
    end

    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'd4, 16'd0, 3, 8, 1'b0, obs);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 16'd3, 16'd0, 1, 1, 1'b0, obs);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 16'd0, 1, 1, 1'b1, obs);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'd1, 1, 1, 1'b0, obs);

    for (int k = 0; k < 25; k++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      l0 = ($urandom_range(0, 4) == 0) ? '0 : LW'($urandom_range(1, 65535));
      l1 = ($urandom_range(0, 4) == 0) ? '0 : LW'($urandom_range(1, 65535));
      apply_stimulus(r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), l0, l1,
                     int'($urandom_range(1, 6)), int'($urandom_range(1, 8)),
                     ($urandom_range(0, 7) == 0), obs);
    end

    // Abort during RUN: everything clears at once and no completion is reported.
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b0; op0 = 1'b1; len0 = 16'd5;
    @(posedge clk); #1;
    @(negedge clk); busy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_output("pre_abort_gnt", 32'({gnt1, gnt0, work}), 32'b010);
    @(negedge clk); rst = 1'b0;
    #1;
    check_output("abort_outs", 32'({gnt1, gnt0, done1, done0, work, err, op, sel}), 32'd0);
    check_output("abort_len", 32'(len), 32'd0);
    last_m = 1'b1;
    busy = 1'b0; req0 = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check_output("abort_quiet", 32'({done1, done0, err}), 32'd0);
    end
    @(negedge clk); rst = 1'b1;
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'd6, 16'd6, 2, 3, 1'b0, obs);
    check_output("post_abort_sel", 32'(obs), 32'd1);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'd1, 16'd2, 1, 2, 1'b0, obs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
